// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory responder.
//   XLEN        : machine word width
//   F3_*        : load/store funct3 width codes
//   state_t     : responder FSM encoding (IDLE, BUSY, RESP)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the processor datapath (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   mem_read/mem_write  : request type (both high = store)
//   funct3, addr, wdata : RV32I width code, byte address, right-aligned store data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata, rsp_err  : extended load data / access error, valid with rsp_valid
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and at least one of mem_read/mem_write is set.
// The master holds request fields stable while req_valid is high and
// req_ready is low. Responses have no backpressure: rsp_valid is a single
// cycle pulse the master must take when it appears.
interface dmem_responder_if;
  import riscv_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for RV32I loads and stores.
//   is_store   : 1 = store access, 0 = load access
//   funct3     : width code
//   addr_lo    : byte offset within the word
//   word       : current array word
//   wdata      : right-aligned store data
//   load_val   : extended load value (0 on error or for stores)
//   store_word : word with the store merged into the selected lane(s)
//   err        : illegal funct3, or misaligned when DMEM_MISALIGN_TRAP_EN is defined
// Without DMEM_MISALIGN_TRAP_EN, misaligned halfword/word accesses are
// aligned down: the halfword lane uses addr_lo[1] only and words ignore addr_lo.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] store_word,
  output logic            err
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        illegal;
  logic        misalign;

  always_comb begin
    ld_byte = word[{addr_lo, 3'b000} +: 8];
    ld_half = word[{addr_lo[1], 4'b0000} +: 16];

    if (is_store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else          illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
    misalign = 1'b0;
`endif

    err = illegal | misalign;

    load_val = '0;
    if (!is_store && !err) begin
      case (funct3)
        F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
        F3_BU:   load_val = {24'd0, ld_byte};
        F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
        F3_HU:   load_val = {16'd0, ld_half};
        F3_W:    load_val = word;
        default: load_val = '0;
      endcase
    end

    store_word = word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES extra cycles, then pulses a response. Loads are extracted and
// extended per RV32I; stores are byte-merged into a 2**ADDR_W word array.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_responder_if slave modport (request/response)
//   dbg_state  : current FSM state for observation
// Optional: DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into
// errors instead of aligning them down.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output state_t             dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [XLEN-1:0]   mem [2**ADDR_W];

  logic              accept;
  logic              done;
  logic [XLEN-1:0]   cur_word;
  logic [XLEN-1:0]   al_load;
  logic [XLEN-1:0]   al_store;
  logic              al_err;

  logic              req_ready_c;
  logic              rsp_valid_c;
  logic [XLEN-1:0]   rsp_rdata_c;
  logic              rsp_err_c;

  assign cur_word = mem[addr_q[ADDR_W+1:2]];

  dmem_lane_align u_align (
    .is_store   (store_q),
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (cur_word),
    .wdata      (wdata_q),
    .load_val   (al_load),
    .store_word (al_store),
    .err        (al_err)
  );

  // Next state and outputs. req_ready is also gated by reset so it reads 0
  // for the whole time reset is held.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    done        = 1'b0;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_rdata_c = '0;
    rsp_err_c   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = !reset;
        accept      = bus.req_valid && (bus.mem_read || bus.mem_write);
        if (accept) state_n = BUSY;
      end
      BUSY: begin
        done = (cnt == '0);
        if (done) state_n = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = rdata_q;
        rsp_err_c   = err_q;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt     <= CNT_W'(WAIT_CYCLES);
        addr_q  <= bus.addr[ADDR_W+1:0];
        wdata_q <= bus.wdata;
        f3_q    <= bus.funct3;
        // mem_read together with mem_write is treated as a store.
        store_q <= bus.mem_write;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Load data is captured on the same edge a store commits, so a load
      // only ever sees stores that reached RESP earlier.
      if (done) begin
        rdata_q <= store_q ? '0 : al_load;
        err_q   <= al_err;
      end
    end
  end

  // Array has no reset; a store abandoned by reset before the commit edge
  // never writes.
  always_ff @(posedge clk) begin
    if (!reset && done && store_q && !al_err)
      mem[addr_q[ADDR_W+1:2]] <= al_store;
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rsp_rdata_c;
  assign bus.rsp_err   = rsp_err_c;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import riscv_pkg::*;

  localparam int ADDR_W = 6;
  localparam int WAIT   = 2;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LAT    = 2 + WAIT;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: word array plus RV32I lane rules in plain arithmetic.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int          idx;
    int          off;
    int          size;
    bit          legal;
    logic [63:0] mask;
    logic [63:0] shifted;
    logic [31:0] w;
    logic [31:0] v;
    idx  = int'((a >> 2) % DEPTH);
    off  = int'(a % 4);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    rd = '0;
    er = 1'b0;
    if (!legal) begin
      er = 1'b1;
      return;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if (off % size != 0) begin
      er = 1'b1;
      return;
    end
`else
    off = off - (off % size);
`endif
    w = exp_mem[idx];
    if (st) begin
      mask    = ((64'd1 << (8 * size)) - 64'd1) << (8 * off);
      shifted = (64'(wd) << (8 * off)) & mask;
      exp_mem[idx] = (w & ~mask[31:0]) | shifted[31:0];
    end else begin
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v - 32'h100;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
      end
      rd = v;
    end
  endfunction

  // ---------------- driver ----------------
  // Entered and left on a falling edge with the responder idle.
  task automatic xact(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err, output int lat);
    bit got;
    chk("req_ready_before", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.mem_read  = rd_en;
    bus.mem_write = wr_en;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    got   = 1'b0;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) begin
        got   = 1'b1;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("rsp_pulse_len", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rdata_idle", bus.rsp_rdata, 32'd0);
  endtask

  // One request checked against the model via the expected queue.
  task automatic run(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] m_rd, g_rd;
    logic        m_er, g_er;
    int          lat;
    model(wr_en, f3, a, wd, m_rd, m_er);
    exp_q.push_back(m_rd);
    exp_q.push_back({31'd0, m_er});
    xact(rd_en, wr_en, f3, a, wd, g_rd, g_er, lat);
    chk({tag, "_rdata"}, g_rd, exp_q.pop_front());
    chk({tag, "_err"}, {31'd0, g_er}, exp_q.pop_front());
    chk({tag, "_lat"}, lat, LAT);
  endtask

  // Directed load/store with a fixed expectation, also keeping the model in step.
  task automatic run_k(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] k_rd, input logic k_er, input string tag);
    logic [31:0] m_rd, g_rd;
    logic        m_er, g_er;
    int          lat;
    model(wr_en, f3, a, wd, m_rd, m_er);
    xact(rd_en, wr_en, f3, a, wd, g_rd, g_er, lat);
    chk({tag, "_rdata"}, g_rd, k_rd);
    chk({tag, "_err"}, {31'd0, g_er}, {31'd0, k_er});
    chk({tag, "_lat"}, lat, LAT);
  endtask

  logic [2:0] legal_ld [5];
  logic [2:0] legal_st [3];

  initial begin
    legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    legal_st = '{3'b000, 3'b001, 3'b010};
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.funct3    = '0;
    bus.addr      = '0;
    bus.wdata     = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Request with neither read nor write is ignored
    bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("null_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("null_req_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.req_valid = 1'b0;

    // Word store then load, and lane extraction
    run_k(1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    run_k(1'b1, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    run_k(1'b1, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    run_k(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    run_k(1'b1, 1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    run_k(1'b1, 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    run_k(1'b0, 1'b1, F3_B,  32'h11, 32'h55, 32'h0, 1'b0, "sb_11");
    run_k(1'b1, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after_sb");
    run_k(1'b0, 1'b1, F3_H,  32'h16, 32'hAAAA1234, 32'h0, 1'b0, "sh_16");
    run_k(1'b1, 1'b1, F3_W,  32'h18, 32'h0BADC0DE, 32'h0, 1'b0, "rw_is_store");
    run_k(1'b1, 1'b0, F3_W,  32'h18, 32'h0, 32'h0BADC0DE, 1'b0, "lw_18");

    // Address wrap
    run_k(1'b0, 1'b1, F3_W, 32'h100, 32'h12345678, 32'h0, 1'b0, "sw_wrap");
    run_k(1'b1, 1'b0, F3_W, 32'h000, 32'h0, 32'h12345678, 1'b0, "lw_wrap");

    // Illegal funct3 and misalignment
    run_k(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    run_k(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_100");
    run_k(1'b1, 1'b0, F3_W,   32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_after_illegal_st");
`ifdef DMEM_MISALIGN_TRAP_EN
    run_k(1'b1, 1'b0, F3_W, 32'h12, 32'h0, 32'h0, 1'b1, "lw_misalign");
`else
    run_k(1'b1, 1'b0, F3_W, 32'h12, 32'h0, 32'hDEAD55EF, 1'b0, "lw_misalign");
`endif

    // Reset while a store waits in BUSY
    run_k(1'b0, 1'b1, F3_W, 32'h20, 32'h01234567, 32'h0, 1'b0, "sw_20_prior");
    chk("ready_before_abort", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.mem_write = 1'b1;
    bus.funct3    = F3_W;
    bus.addr      = 32'h20;
    bus.wdata     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready_in_reset", {31'd0, bus.req_ready}, 32'd0);
    chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_quiet", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_k(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 32'h01234567, 1'b0, "lw_20_after_abort");

    // Initialise every word, then random traffic against the model
    for (int i = 0; i < DEPTH; i++)
      run(1'b0, 1'b1, F3_W, 32'(i * 4), $urandom(), "fill");
    for (int i = 0; i < 120; i++) begin
      int          kind;
      logic [2:0]  f3;
      logic        rd_en, wr_en;
      kind  = $urandom_range(0, 9);
      rd_en = (kind <= 4) || (kind == 9);
      wr_en = (kind >= 5);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr_en) f3 = legal_st[$urandom_range(0, 2)];
      else            f3 = legal_ld[$urandom_range(0, 4)];
      run(rd_en, wr_en, f3, $urandom(), $urandom(), "rand");
    end
    for (int i = 0; i < DEPTH; i++)
      run(1'b1, 1'b0, F3_W, 32'(i * 4), 32'h0, "readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the processor's load/store interface (mem_read, mem_write, funct3, address, store data).
- Accepts one request at a time, inserts a configurable number of wait states, and returns load data with RV32I byte/halfword extraction and sign extension.
- Applies byte-merged stores into an internal word array.
- Sits between the Datapath memory port and the backing storage. It is the block the multi-cycle and pipelined processor variants will use in place of the single-cycle combinational memory.

Parameters:
- ADDR_W, 6, word-address width; the array holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra cycles between request accept and response (0 allowed).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- mem_read  input  1  load request
- mem_write  input  1  store request
- funct3  input  3  RV32I load/store width code
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  extended load data; 0 for stores
- rsp_err  output  1  access error, valid with rsp_valid

Behaviour:
- Interface is as decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - FSM goes to IDLE.
  - req_ready=0 while reset is high and 1 on the first cycle after reset deasserts.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. Accept when req_valid & (mem_read | mem_write). On accept, latch addr, wdata, funct3 and request type, load the wait counter with WAIT_CYCLES, and go to BUSY.
  - req_valid with neither mem_read nor mem_write asserted is ignored; stay in IDLE.
  - BUSY: req_ready=0. If the counter is 0, go to RESP and decrement nothing; otherwise decrement.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency: request accepted at edge N gives rsp_valid high in cycle N+2+WAIT_CYCLES. The next accept is possible one cycle after RESP.
- Between responses, rsp_rdata and rsp_err hold 0.
- Simultaneous mem_read and mem_write: treated as a store; rsp_rdata=0.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo the array size.
- Loads, with lane selected by addr[1:0] (byte) or addr[1] (halfword):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
- Stores:
  - 000 SB: merge wdata[7:0] into the selected byte lane.
  - 001 SH: merge wdata[15:0] into the selected halfword.
  - 010 SW: write the full word.
- Store commit: the array is written on the edge BUSY→RESP, so it is visible to any later request.
- Load read timing: data is read on the same edge, so a load never observes a store that has not yet reached RESP.
- Illegal funct3 (loads 011/110/111, stores 011–111): no array write, rsp_rdata=0, rsp_err=1.
- Reset mid-operation (BUSY or RESP): the transaction is abandoned and no response is issued. A store not yet committed is dropped; a committed store stays.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 gives rsp_err=1, rsp_rdata=0 and no array write.
- Undefined: the offending low address bits are forced to 0 (access is aligned down) and rsp_err stays 0 for legal funct3.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encodings for IDLE, BUSY and RESP;
  - the 32-bit XLEN constant.
- One combinational sub-module, dmem_lane_align:
  - inputs: funct3, addr[1:0], the array word and wdata;
  - outputs: the extended load value, the merged store word and the illegal/misaligned flag.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- Reset, then idle: req_ready=0 during reset and 1 after; rsp_valid stays 0 for 10 cycles.
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 with WAIT_CYCLES=2: each rsp_valid arrives exactly 4 cycles after accept; the load returns rsp_rdata=0xDEADBEEF with rsp_err=0.
- With word 0x10 holding 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x12 → 0xFFFFDEAD;
  - SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF.
- Wrap with ADDR_W=6: SW 0x12345678 to 0x100, then LW 0x000 → 0x12345678.
- funct3=011 load → rsp_err=1, rsp_rdata=0. LW 0x12 → with DMEM_MISALIGN_TRAP_EN rsp_err=1; without it, returns the word at 0x10 with rsp_err=0.
- Reset asserted in BUSY during SW 0xCAFEF00D to 0x20: no rsp_valid, and a later LW 0x20 returns the prior contents.
